// File: rtl/sevenseg_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with per-frame snapshot,
// inter-digit blanking and 3-bit brightness PWM.
module sevenseg_scan_driver #(
    parameter int unsigned DIV            = 50000,
    parameter int unsigned BLANK          = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i_En,
    input  logic [6:0] i_Seg0,
    input  logic [6:0] i_Seg1,
    input  logic [6:0] i_Seg2,
    input  logic [6:0] i_Seg3,
    input  logic [6:0] i_Seg4,
    input  logic [6:0] i_Seg5,
    input  logic [5:0] i_DpMask,
    input  logic [2:0] i_Bright,
    output logic [6:0] o_Seg,
    output logic       o_Dp,
    output logic [5:0] o_Dig,
    output logic       o_FrameStart
);

    localparam int unsigned PW = 16;
    localparam int unsigned MW = 24;

    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_P    = PW'(BLANK);
    localparam logic [MW-1:0] ON_SPAN    = MW'(DIV - BLANK);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [5:0] DIG_OFF = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

    typedef enum logic [1:0] {
        REGION_BLANK,
        REGION_ON,
        REGION_OFF
    } region_e;

    logic [PW-1:0]    phase_q, phase_d;
    logic [2:0]       slot_q, slot_d;
    logic [5:0][6:0]  shadow_seg_q, shadow_seg_d;
    logic [5:0]       shadow_dp_q, shadow_dp_d;
    logic [2:0]       shadow_bright_q, shadow_bright_d;
    logic             frame_start_q, frame_start_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [5:0]       dig_q, dig_d;

    logic             snapshot;
    logic [MW-1:0]    offset_x8;
    logic [MW-1:0]    lit_limit;
    logic [5:0]       dig_onehot;
    region_e          region;

    // Counters and snapshot capture.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        phase_d         = phase_q;
        slot_d          = slot_q;
        shadow_seg_d    = shadow_seg_q;
        shadow_dp_d     = shadow_dp_q;
        shadow_bright_d = shadow_bright_q;
        snapshot        = i_En && (slot_q == 3'd0) && (phase_q == '0);

        if (!i_En) begin
            phase_d = '0;
            slot_d  = '0;
        end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            slot_d  = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
        end else begin
            phase_d = phase_q + PW'(1);
        end

        if (snapshot) begin
            shadow_seg_d    = {i_Seg5, i_Seg4, i_Seg3, i_Seg2, i_Seg1, i_Seg0};
            shadow_dp_d     = i_DpMask;
            shadow_bright_d = i_Bright;
        end

        frame_start_d = snapshot;
    end

    // Slot region: blank gap, then a PWM-lit window sized by brightness.
    always_comb begin
        offset_x8  = MW'(phase_q - BLANK_P) << 3;
        lit_limit  = ON_SPAN * (MW'(shadow_bright_q) + MW'(1));
        dig_onehot = 6'd1 << slot_q;

        if (phase_q < BLANK_P) begin
            region = REGION_BLANK;
        end else if (offset_x8 < lit_limit) begin
            region = REGION_ON;
        end else begin
            region = REGION_OFF;
        end

        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        dig_d = DIG_OFF;
        if (i_En && (region == REGION_ON)) begin
            dig_d = DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
            seg_d = SEG_ACTIVE_LOW ? ~shadow_seg_q[slot_q] : shadow_seg_q[slot_q];
            dp_d  = SEG_ACTIVE_LOW ? ~shadow_dp_q[slot_q] : shadow_dp_q[slot_q];
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            phase_q         <= '0;
            slot_q          <= '0;
            // NOTE: the shadow array is tiny and must read as blank after
            // reset, so each entry is reset rather than left as RAM.
            shadow_seg_q    <= '0;
            shadow_dp_q     <= '0;
            shadow_bright_q <= '0;
            frame_start_q   <= 1'b0;
            seg_q           <= SEG_OFF;
            dp_q            <= DP_OFF;
            dig_q           <= DIG_OFF;
        end else begin
            phase_q         <= phase_d;
            slot_q          <= slot_d;
            shadow_seg_q    <= shadow_seg_d;
            shadow_dp_q     <= shadow_dp_d;
            shadow_bright_q <= shadow_bright_d;
            frame_start_q   <= frame_start_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            dig_q           <= dig_d;
        end
    end

    assign o_Seg        = seg_q;
    assign o_Dp         = dp_q;
    assign o_Dig        = dig_q;
    assign o_FrameStart = frame_start_q;

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Display-side reader of the stopwatch's six parallel 7-segment digit patterns.
- Time-multiplexes the six patterns onto one shared segment bus with six digit enables for the board's common-anode display.
- Snapshots all six patterns once per frame so no frame mixes two stopwatch values.
- Adds an inter-digit blanking gap against ghosting, a 3-bit brightness PWM, and a frame-start pulse.

Parameters:
- DIV, 50000, clocks per digit slot; legal range 10 to 65535; the bench overrides it to 18.
- BLANK, 2, clocks at the start of each slot with everything off; legal range 1 to DIV-8.
- SEG_ACTIVE_LOW, 1, 1 means o_Seg and o_Dp are driven 0 to light a segment.
- DIG_ACTIVE_LOW, 1, 1 means o_Dig bits are driven 0 to enable a digit.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- i_En  in  1  scan enable.
- i_Seg0..i_Seg5  in  7 each  digit patterns, bit0=a .. bit6=g, 1 means lit; i_Seg0 is the rightmost digit.
- i_DpMask  in  6  decimal point per digit, 1 means lit.
- i_Bright  in  3  brightness, 0 is dimmest and 7 is brightest.
- o_Seg  out  7  shared segment bus, polarity set by SEG_ACTIVE_LOW.
- o_Dp  out  1  shared decimal point, polarity set by SEG_ACTIVE_LOW.
- o_Dig  out  6  digit enables, one-hot or all-off, polarity set by DIG_ACTIVE_LOW.
- o_FrameStart  out  1  one-clock pulse when a new frame snapshot is taken.

Behaviour:
- Counters: phase counter 0..DIV-1 and slot counter 0..5. Phase increments each clock while i_En=1. When phase goes from DIV-1 to 0, slot increments, wrapping from 5 to 0.
- Snapshot: on each edge taken with (slot=0, phase=0, i_En=1), capture i_Seg0..5, i_DpMask and i_Bright into shadow registers, and assert o_FrameStart for the following cycle only. Input changes between snapshots have no effect on the outputs.
- Per-slot phases:
  - BLANK: phase < BLANK.
  - ON: lit when (phase-BLANK)*8 < (DIV-BLANK)*(shadowBright+1). The product is computed at ≥20+3 bits with no truncation.
  - OFF: remainder of the slot.
- Output content per phase:
  - During ON, o_Dig enables only the digit indexed by slot, and o_Seg/o_Dp carry that digit's shadow pattern and dp.
  - During BLANK and OFF, all digits and all segments are inactive.
- Latency: outputs are registered. The output in cycle k+1 reflects the counter state in cycle k, a fixed latency of 1 clock.
- No overlap: o_Dig is never active in two bits at once. No digit is enabled in the first cycle after a slot change, which is guaranteed by BLANK ≥ 1.
- i_En=0: on the next edge, counters clear to (slot 0, phase 0), outputs go inactive and o_FrameStart=0; shadow registers hold. On re-enable, the first edge takes a fresh snapshot and restarts at digit 0.
- Reset (Rst=0, any time including mid-slot): immediately forces the following, independent of Clk:
  - phase=0, slot=0;
  - shadow patterns, dp and bright = 0;
  - o_FrameStart=0;
  - o_Dig and o_Seg/o_Dp at their inactive level (all 1s with default parameters).
  - After release, operation restarts as described for i_En.
- Brightness 7: lit for all DIV-BLANK cycles of the slot. Brightness 0: lit for ceil((DIV-BLANK)/8) cycles.
- Frame period: exactly 6*DIV clocks, so o_FrameStart pulses every 6*DIV clocks while enabled.

Test Plan:
- Reset and release with i_En=1, DIV=18, BLANK=2, i_Bright=7, i_Seg0=7'h3F, others 7'h06:
  - o_FrameStart is high for one cycle and repeats every 108 clocks.
  - o_Dig=6'b111110 for 16 consecutive clocks, starting 3 clocks after the snapshot edge (2 blank + 1 latency).
  - o_Seg=~7'h3F meanwhile, then the bus goes all-off for 2 clocks before o_Dig=6'b111101.
- i_Bright=0: each digit is lit for exactly 2 clocks per slot. i_Bright=3: each digit is lit for exactly 8 clocks per slot.
- Change i_Seg3 mid-frame, during slot 1: digit 3 still shows the old pattern in this frame and the new pattern from the next frame.
- i_DpMask=6'b000100: o_Dp is active only while o_Dig selects digit 2.
- Assert Rst=0 mid-ON of digit 4: all outputs go inactive with no clock edge. After release, the scan restarts at digit 0 with o_FrameStart.
- Drop i_En for 5 clocks during slot 3: outputs are off from the next edge. Re-enable: snapshot and o_FrameStart on the first edge, digit 0 lit after 3 clocks.
- Throughout all scenarios, a continuous checker flags any cycle with more than one o_Dig bit active.
